// File: rtl/soc_system_key_pio.sv
// soc_system_key_pio
//   Avalon-MM key/button PIO. Synchronizes active-low key inputs, optionally
//   debounces them, latches falling edges into a write-1-to-clear capture
//   register and raises a masked level interrupt.
//
//   Optional feature macro: KEY_PIO_DEBOUNCE_EN
//     undefined : filtered value is the synchronizer output, no counters
//     defined   : per-bit 16-bit stability counter of DEBOUNCE_CYCLES clocks
//
//   Ports
//     clk        in   single clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     address    in   2   word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//     chipselect in   1   slave select
//     write_n    in   1   active-low write strobe
//     writedata  in   32  write data, [WIDTH-1:0] used
//     in_port    in   WIDTH  asynchronous active-low keys, idle high
//     readdata   out  32  combinational read mux
//     irq        out  1   level interrupt, active-high
module soc_system_key_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] f_prev_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic             wr_en;
    logic [WIDTH-1:0] clr_bits;

    // Upper writedata bits and, in the default build, the debounce length
    // have no function; fold them into a sink so lint stays quiet.
    logic unused_ok;
    assign unused_ok = ^{writedata, 32'(DEBOUNCE_CYCLES)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] filt_q;
    logic [15:0]      cnt_q [WIDTH];

    // A bit's filtered value follows sync2 only after it has disagreed for
    // DEBOUNCE_CYCLES consecutive clocks; any agreeing clock restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        filt_q[i] <= sync2_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 16'd1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign wr_en    = chipselect & ~write_n;
    assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && address == 2'd2) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        // New falling edges are OR-ed in after the clear so set wins.
        edge_cap_d = (edge_cap_q & ~clr_bits) | (f_prev_q & ~filt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_prev_q   <= '1;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            f_prev_q   <= filt;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = filt;
            2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata[WIDTH-1:0] = edge_cap_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_key_pio.sv
module tb_soc_system_key_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    int n_pass = 0;
    int n_total = 0;

    soc_system_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in_v;
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    logic [31:0] r;

    initial begin
        // reset asserted before any clock edge
        #1 reset_n = 1'b0;
        #1;
        rd(2'd0, r); check("reset_data", r, 32'hF);
        rd(2'd2, r); check("reset_mask", r, 32'h0);
        rd(2'd3, r); check("reset_edge", r, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

`ifndef KEY_PIO_DEBOUNCE_EN
        //            in    wr    wa    wdata          ra    exp_rd         irq
        vecs[0]  = '{4'hF, 1'b1, 2'd2, 32'h4,        2'd2, 32'h4,        1'b0};
        vecs[1]  = '{4'hB, 1'b0, 2'd0, 32'h0,        2'd0, 32'hF,        1'b0};
        vecs[2]  = '{4'hB, 1'b0, 2'd0, 32'h0,        2'd0, 32'hB,        1'b0};
        vecs[3]  = '{4'hB, 1'b0, 2'd0, 32'h0,        2'd3, 32'h4,        1'b1};
        vecs[4]  = '{4'hB, 1'b1, 2'd3, 32'h4,        2'd3, 32'h0,        1'b0};
        vecs[5]  = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd0, 32'hB,        1'b0};
        vecs[6]  = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd0, 32'hF,        1'b0};
        vecs[7]  = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
        vecs[8]  = '{4'hF, 1'b1, 2'd0, 32'h0,        2'd0, 32'hF,        1'b0};
        vecs[9]  = '{4'hF, 1'b1, 2'd1, 32'hF,        2'd1, 32'h0,        1'b0};
        vecs[10] = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd2, 32'h4,        1'b0};
        vecs[11] = '{4'hF, 1'b1, 2'd2, 32'hFFFFFFF0, 2'd2, 32'h0,        1'b0};
        vecs[12] = '{4'hE, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
        vecs[13] = '{4'hE, 1'b0, 2'd0, 32'h0,        2'd0, 32'hE,        1'b0};
        vecs[14] = '{4'hE, 1'b0, 2'd0, 32'h0,        2'd3, 32'h1,        1'b0};
        vecs[15] = '{4'hE, 1'b1, 2'd2, 32'h1,        2'd2, 32'h1,        1'b1};
        vecs[16] = '{4'hF, 1'b1, 2'd3, 32'h1,        2'd3, 32'h0,        1'b0};
        vecs[17] = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd0, 32'hF,        1'b0};
        vecs[18] = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
        vecs[19] = '{4'hD, 1'b0, 2'd0, 32'h0,        2'd0, 32'hF,        1'b0};
        vecs[20] = '{4'hD, 1'b0, 2'd0, 32'h0,        2'd0, 32'hD,        1'b0};
        vecs[21] = '{4'hD, 1'b1, 2'd3, 32'h2,        2'd3, 32'h2,        1'b0};
        vecs[22] = '{4'hD, 1'b1, 2'd3, 32'h2,        2'd3, 32'h0,        1'b0};
        vecs[23] = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd0, 32'hD,        1'b0};
        vecs[24] = '{4'hF, 1'b0, 2'd0, 32'h0,        2'd0, 32'hF,        1'b0};
        vecs[25] = '{4'h0, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
        vecs[26] = '{4'h0, 1'b0, 2'd0, 32'h0,        2'd0, 32'h0,        1'b0};
        vecs[27] = '{4'h0, 1'b0, 2'd0, 32'h0,        2'd3, 32'hF,        1'b1};
        vecs[28] = '{4'hF, 1'b1, 2'd3, 32'hA,        2'd3, 32'h5,        1'b1};
        vecs[29] = '{4'hF, 1'b1, 2'd3, 32'h5,        2'd3, 32'h0,        1'b0};

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            in_port    = vecs[i].in_v;
            chipselect = vecs[i].wr;
            write_n    = ~vecs[i].wr;
            address    = vecs[i].waddr;
            writedata  = vecs[i].wdata;
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            write_n    = 1'b1;
            rd(vecs[i].raddr, r);
            check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // asynchronous reset between clock edges with a pending interrupt
        @(negedge clk);
        in_port = 4'hE;
        repeat (3) @(posedge clk);
        #1;
        rd(2'd3, r); check("pre_areset_edge", r, 32'h1);
        check("pre_areset_irq", {31'd0, irq}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        rd(2'd3, r); check("areset_edge", r, 32'h0);
        rd(2'd2, r); check("areset_mask", r, 32'h0);
        rd(2'd0, r); check("areset_data", r, 32'hF);
        check("areset_irq", {31'd0, irq}, 32'h0);
        in_port = 4'hF;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd(2'd3, r); check("post_areset_edge", r, 32'h0);
`else
        // 5-clock glitch on bit 3 must be rejected
        @(negedge clk);
        in_port = 4'h7;
        repeat (5) @(negedge clk);
        in_port = 4'hF;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            rd(2'd0, r); check($sformatf("glitch_data%0d", n), r, 32'hF);
        end
        rd(2'd3, r); check("glitch_edge", r, 32'h0);

        // 20-clock low: sync2 falls after edge 2, filtered value after edge 10
        @(negedge clk);
        in_port = 4'h7;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            rd(2'd0, r);
            check($sformatf("deb_data_e%0d", n), r, (n >= 10) ? 32'h7 : 32'hF);
        end
        rd(2'd3, r); check("deb_edge", r, 32'h8);
        @(negedge clk);
        in_port = 4'hF;
        repeat (15) @(posedge clk);
        #1;
        rd(2'd0, r); check("deb_release_data", r, 32'hF);
        do_write(2'd3, 32'hF);
        do_write(2'd2, 32'hF);
        rd(2'd3, r); check("deb_cleared", r, 32'h0);

        // reset in the middle of a debounce count (count 5 of 8)
        @(negedge clk);
        in_port = 4'h7;
        repeat (7) @(posedge clk);
        #2 reset_n = 1'b0;
        in_port = 4'hF;
        #1;
        rd(2'd0, r); check("midrst_data", r, 32'hF);
        @(negedge clk);
        reset_n = 1'b1;
        do_write(2'd2, 32'hF);
        repeat (20) @(posedge clk);
        #1;
        rd(2'd0, r); check("midrst_data_after", r, 32'hF);
        rd(2'd3, r); check("midrst_edge", r, 32'h0);
        check("midrst_irq", {31'd0, irq}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
